// File: rtl/alu_mc.sv
// alu_mc: registered, parametrised ALU with a start/done handshake.
// Ops: 000 add, 001 and, 010 or, 011 slt, 100 sub, 101 mul (110/111 reserved).
// Build option: define ALU_MC_MUL_EN to include the sequential shift-add
// multiplier for op 101. Without it, op 101 behaves as a reserved op.
// Operands are captured on the start edge. The result and all flags are
// registered in DONE and held until the next done edge or reset.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             SLT,
    output logic             zero,
    output logic             GT,
    output logic             OV
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
`ifdef ALU_MC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b101;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
`ifdef ALU_MC_MUL_EN
        ST_MUL  = 2'b01,
`endif
        ST_DONE = 2'b10
    } state_t;

    // Signed overflow of x + y: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of x - y: operands differ in sign, result sign flips away from x.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    state_t           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             done_r;
    logic [WIDTH-1:0] res_r;
    logic             slt_r;
    logic             zero_r;
    logic             gt_r;
    logic             ov_r;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             slt_s;
    logic             eq_s;
    logic             gt_s;
    logic [WIDTH-1:0] res_s;
    logic             ov_s;

`ifdef ALU_MC_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] pp_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic               last_s;

    // One shift-add step per cycle: add x shifted by the current bit index when that multiplier bit is set.
    always_comb begin
        pp_s   = {{WIDTH{1'b0}}, x_r} << cnt_r;
        last_s = (cnt_r == CW'(WIDTH - 1));
        if (y_r[cnt_r]) begin
            acc_nxt_s = acc_r + pp_s;
        end else begin
            acc_nxt_s = acc_r;
        end
    end
`endif

    // Result and flag datapath, evaluated from the captured operands.
    always_comb begin
        sum_s  = x_r + y_r;
        diff_s = x_r - y_r;
        slt_s  = ($signed(x_r) < $signed(y_r));
        eq_s   = (x_r == y_r);
        gt_s   = ~(eq_s | slt_s);
        res_s  = {WIDTH{1'b0}};
        ov_s   = 1'b0;
        case (op_r)
            OP_ADD: begin
                res_s = sum_s;
                ov_s  = add_ovf(x_r[WIDTH-1], y_r[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_AND: begin
                res_s = x_r & y_r;
                ov_s  = 1'b0;
            end
            OP_OR: begin
                res_s = x_r | y_r;
                ov_s  = 1'b0;
            end
            OP_SLT: begin
                res_s = {{(WIDTH-1){1'b0}}, slt_s};
                ov_s  = 1'b0;
            end
            OP_SUB: begin
                res_s = diff_s;
                ov_s  = sub_ovf(x_r[WIDTH-1], y_r[WIDTH-1], diff_s[WIDTH-1]);
            end
`ifdef ALU_MC_MUL_EN
            OP_MUL: begin
                res_s = acc_r[WIDTH-1:0];
                ov_s  = |acc_r[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
                res_s = {WIDTH{1'b0}};
                ov_s  = 1'b0;
            end
        endcase
    end

    // Control FSM: operand capture, multiplier iteration and registered result/flag update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= 3'b000;
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
            res_r   <= {WIDTH{1'b0}};
            slt_r   <= 1'b0;
            zero_r  <= 1'b1;
            gt_r    <= 1'b0;
            ov_r    <= 1'b0;
`ifdef ALU_MC_MUL_EN
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r <= op;
                        x_r  <= x;
                        y_r  <= y;
`ifdef ALU_MC_MUL_EN
                        if (op == OP_MUL) begin
                            acc_r   <= {(2*WIDTH){1'b0}};
                            cnt_r   <= {CW{1'b0}};
                            state_r <= ST_MUL;
                        end else begin
                            state_r <= ST_DONE;
                        end
`else
                        state_r <= ST_DONE;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
`ifdef ALU_MC_MUL_EN
                ST_MUL: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
`endif
                ST_DONE: begin
                    res_r   <= res_s;
                    slt_r   <= slt_s;
                    zero_r  <= (res_s == {WIDTH{1'b0}});
                    gt_r    <= gt_s;
                    ov_r    <= ov_s;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);
    assign done = done_r;
    assign res  = res_r;
    assign SLT  = slt_r;
    assign zero = zero_r;
    assign GT   = gt_r;
    assign OV   = ov_r;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=16).
// Expectations for op 101 follow ALU_MC_MUL_EN as seen by this file.
module tb_alu_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] x = 16'h0000;
    logic [W-1:0] y = 16'h0000;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic         SLT;
    logic         zero;
    logic         GT;
    logic         OV;

    int tests = 0;
    int fails = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
        .busy(busy), .done(done), .res(res), .SLT(SLT), .zero(zero), .GT(GT), .OV(OV)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one sampling edge, then scramble the operand inputs.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; x = a; y = b; start = 1'b1;
        step();
        start = 1'b0; op = 3'b111; x = 16'hDEAD; y = 16'hBEEF;
    endtask

    // Count edges since start until done rises (bounded).
    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (done !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        if (done !== 1'b1) begin
            tests++; fails++;
            $display("FAIL wait_done: got no done after %0d edges, required a done pulse", edges);
        end
    endtask

    task automatic test_reset();
        step(); step();
        tests++; if ({busy, done, SLT, zero, GT, OV} !== 6'b000100) begin fails++; $display("FAIL reset flags: got %b required %b", {busy, done, SLT, zero, GT, OV}, 6'b000100); end
        tests++; if (res !== 16'h0000) begin fails++; $display("FAIL reset res: got %h required %h", res, 16'h0000); end
        rst = 1'b0;
    endtask

    task automatic test_add_ov();
        int e;
        launch(3'b000, 16'h7FFF, 16'h0001);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL add busy: got %b required 1", busy); end
        wait_done(1, e);
        tests++; if (e != 2) begin fails++; $display("FAIL add latency: got %0d required 2", e); end
        tests++; if (res !== 16'h8000) begin fails++; $display("FAIL add res: got %h required %h", res, 16'h8000); end
        tests++; if ({SLT, zero, GT, OV} !== 4'b0011) begin fails++; $display("FAIL add flags SLT/zero/GT/OV: got %b required %b", {SLT, zero, GT, OV}, 4'b0011); end
        step();
        tests++; if ({done, busy} !== 2'b00 || res !== 16'h8000) begin fails++; $display("FAIL add hold: got done/busy %b res %h required 00 and 8000", {done, busy}, res); end
    endtask

    task automatic test_reset_mid_op();
        bit saw_done;
        launch(3'b101, 16'h0003, 16'h0005);
`ifdef ALU_MC_MUL_EN
        step(); step(); step();
`endif
        rst = 1'b1;
        step();
        tests++; if ({busy, done, SLT, zero, GT, OV} !== 6'b000100) begin fails++; $display("FAIL rst_mid flags: got %b required %b", {busy, done, SLT, zero, GT, OV}, 6'b000100); end
        tests++; if (res !== 16'h0000) begin fails++; $display("FAIL rst_mid res: got %h required %h", res, 16'h0000); end
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
        end
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rst_mid no_done: got activity %b required 0", saw_done); end
    endtask

    task automatic test_sub();
        int e;
        launch(3'b100, 16'h1234, 16'h1234);
        wait_done(1, e);
        tests++; if (e != 2 || res !== 16'h0000) begin fails++; $display("FAIL sub_eq res: got %h after %0d edges required 0000 after 2", res, e); end
        tests++; if ({SLT, zero, GT, OV} !== 4'b0100) begin fails++; $display("FAIL sub_eq flags: got %b required %b", {SLT, zero, GT, OV}, 4'b0100); end
        step();
        launch(3'b100, 16'h8000, 16'h0001);
        wait_done(1, e);
        tests++; if (res !== 16'h7FFF || {SLT, zero, GT, OV} !== 4'b1001) begin fails++; $display("FAIL sub_ov: got res %h flags %b required 7fff 1001", res, {SLT, zero, GT, OV}); end
        step();
    endtask

    task automatic test_slt();
        int e;
        launch(3'b011, 16'hFFFF, 16'h0001);
        wait_done(1, e);
        tests++; if (res !== 16'h0001) begin fails++; $display("FAIL slt res: got %h required %h", res, 16'h0001); end
        tests++; if ({SLT, zero, GT, OV} !== 4'b1000) begin fails++; $display("FAIL slt flags: got %b required %b", {SLT, zero, GT, OV}, 4'b1000); end
        step();
    endtask

    task automatic test_mul();
        int  e;
        bit  extra;
`ifdef ALU_MC_MUL_EN
        launch(3'b101, 16'h0100, 16'h0101);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mul busy: got %b required 1", busy); end
        step(); step(); step();
        op = 3'b000; x = 16'h0001; y = 16'h0001; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(5, e);
        tests++; if (e != 18) begin fails++; $display("FAIL mul latency: got %0d required 18", e); end
        tests++; if (res !== 16'h0100 || {SLT, zero, GT, OV} !== 4'b1001) begin fails++; $display("FAIL mul res: got %h flags %b required 0100 1001", res, {SLT, zero, GT, OV}); end
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1 || busy !== 1'b0) extra = 1'b1;
        end
        tests++; if (extra !== 1'b0) begin fails++; $display("FAIL mul ignored_start: got activity %b required 0", extra); end
        launch(3'b101, 16'h0003, 16'h0005);
        wait_done(1, e);
        tests++; if (e != 18 || res !== 16'h000F || OV !== 1'b0) begin fails++; $display("FAIL mul small: got res %h ov %b after %0d edges required 000f 0 after 18", res, OV, e); end
        step();
`else
        launch(3'b101, 16'h0003, 16'h0005);
        wait_done(1, e);
        tests++; if (e != 2) begin fails++; $display("FAIL mul_off latency: got %0d required 2", e); end
        tests++; if (res !== 16'h0000 || {SLT, zero, GT, OV} !== 4'b1100) begin fails++; $display("FAIL mul_off res: got %h flags %b required 0000 1100", res, {SLT, zero, GT, OV}); end
        extra = 1'b0;
        step();
        if (done === 1'b1 || busy !== 1'b0) extra = 1'b1;
        tests++; if (extra !== 1'b0) begin fails++; $display("FAIL mul_off idle: got activity %b required 0", extra); end
`endif
    endtask

    task automatic test_back_to_back();
        int e;
        launch(3'b001, 16'hF0F0, 16'h0FF0);
        wait_done(1, e);
        tests++; if (res !== 16'h00F0 || {SLT, zero, GT, OV} !== 4'b1000) begin fails++; $display("FAIL b2b and: got res %h flags %b required 00f0 1000", res, {SLT, zero, GT, OV}); end
        launch(3'b010, 16'hF0F0, 16'h0FF0);
        tests++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL b2b launch: got busy/done %b required 10", {busy, done}); end
        step();
        tests++; if (done !== 1'b1 || res !== 16'hFFF0 || {SLT, zero, GT, OV} !== 4'b1000) begin fails++; $display("FAIL b2b or: got done %b res %h flags %b required 1 fff0 1000", done, res, {SLT, zero, GT, OV}); end
        step();
    endtask

    initial begin
        test_reset();
        test_add_ov();
        test_reset_mid_op();
        test_sub();
        test_slt();
        test_mul();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
